// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - ASCII constants, command codes and FSM states for the UART command parser
package uart_cmd_pkg;

  localparam int CMD_WORD_W = 34;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [1:0] CMD_ADDR  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WRITE,
    EMIT,
    EMIT_RD
  } state_t;

  function automatic logic [CMD_WORD_W-1:0] make_cmd(input logic [1:0]  cmd_type,
                                                     input logic [31:0] operand);
    return {cmd_type, operand};
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// rtl/hex_ascii_decode.sv - combinational ASCII byte classifier (digit/command/terminator)
// UART_CMD_LOWERCASE_EN: also decode 'a','w','r' and 'b'-'f' like their uppercase forms.
module hex_ascii_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] rx_byte,
  output logic       is_digit,
  output logic [3:0] nibble,
  output logic       is_cmd,
  output logic [1:0] cmd_type,
  output logic       is_term
);

  logic [7:0] ch;

  always_comb begin
    ch = rx_byte;
`ifdef UART_CMD_LOWERCASE_EN
    if (rx_byte >= 8'h61 && rx_byte <= 8'h7A) begin
      ch = rx_byte & 8'hDF;
    end
`else
    ch = rx_byte;
`endif
  end

  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'h0;
    is_cmd   = 1'b0;
    cmd_type = CMD_READ;
    is_term  = 1'b0;

    // 'A' is always the address command, so only 'B'-'F' count as hex letters
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = ch[3:0];
    end else if (ch >= 8'h42 && ch <= 8'h46) begin
      is_digit = 1'b1;
      nibble   = ch[3:0] + 4'd9;
    end else if (ch == ASCII_A) begin
      is_cmd   = 1'b1;
      cmd_type = CMD_ADDR;
    end else if (ch == ASCII_W) begin
      is_cmd   = 1'b1;
      cmd_type = CMD_WRITE;
    end else if (ch == ASCII_R) begin
      is_cmd   = 1'b1;
      cmd_type = CMD_READ;
    end

    if (rx_byte == ASCII_CR || rx_byte == ASCII_LF || rx_byte == ASCII_SPACE) begin
      is_term = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - turns an ASCII command stream into 34-bit bus master command words
// UART_CMD_LOWERCASE_EN (in hex_ascii_decode) enables lowercase command letters and digits.
module uart_cmd_parser
  import uart_cmd_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rx_stb,
  input  logic [7:0]            i_rx_data,
  output logic                  o_cmd_stb,
  output logic [CMD_WORD_W-1:0] o_cmd_word,
  input  logic                  i_cmd_busy,
  output logic [1:0]            o_err
);

  state_t                state_q, state_nxt;
  state_t                ret_q, ret_nxt;
  logic [31:0]           acc_q, acc_nxt;
  logic [CMD_WORD_W-1:0] word_q, word_nxt;
  logic [1:0]            err_q, err_nxt;
  logic                  armed_q;
  logic                  rx_ok;

  logic                  is_digit;
  logic [3:0]            nibble;
  logic                  is_cmd;
  logic [1:0]            cmd_type;
  logic                  is_term;

  hex_ascii_decode u_decode (
    .rx_byte  (i_rx_data),
    .is_digit (is_digit),
    .nibble   (nibble),
    .is_cmd   (is_cmd),
    .cmd_type (cmd_type),
    .is_term  (is_term)
  );

  // a byte strobed in the very first clock after reset release is discarded
  assign rx_ok = i_rx_stb && armed_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ret_q   <= IDLE;
      acc_q   <= '0;
      word_q  <= '0;
      err_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      ret_q   <= ret_nxt;
      acc_q   <= acc_nxt;
      word_q  <= word_nxt;
      err_q   <= err_nxt;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    ret_nxt   = ret_q;
    acc_nxt   = acc_q;
    word_nxt  = word_q;
    err_nxt   = err_q;

    case (state_q)
      IDLE: begin
        if (rx_ok) begin
          if (is_cmd) begin
            acc_nxt = '0;
            case (cmd_type)
              CMD_ADDR:  state_nxt = ADDR;
              CMD_WRITE: state_nxt = WRITE;
              default: begin
                word_nxt  = make_cmd(CMD_READ, 32'h0);
                ret_nxt   = IDLE;
                state_nxt = EMIT;
              end
            endcase
          end else if (!is_term) begin
            err_nxt[0] = 1'b1;
            acc_nxt    = '0;
          end
        end
      end

      ADDR, WRITE: begin
        if (rx_ok) begin
          if (is_digit) begin
            acc_nxt = {acc_q[27:0], nibble};
          end else if (is_term || is_cmd) begin
            word_nxt  = make_cmd((state_q == ADDR) ? CMD_ADDR : CMD_WRITE, acc_q);
            state_nxt = EMIT;
            ret_nxt   = IDLE;
            // a command letter both closes this command and opens the next one
            if (is_cmd) begin
              case (cmd_type)
                CMD_ADDR: begin
                  acc_nxt = '0;
                  ret_nxt = ADDR;
                end
                CMD_WRITE: begin
                  acc_nxt = '0;
                  ret_nxt = WRITE;
                end
                default: ret_nxt = EMIT_RD;
              endcase
            end
          end else begin
            err_nxt[0] = 1'b1;
            acc_nxt    = '0;
            state_nxt  = IDLE;
          end
        end
      end

      EMIT: begin
        if (rx_ok) begin
          err_nxt[1] = 1'b1;
        end
        if (!i_cmd_busy) begin
          state_nxt = ret_q;
          if (ret_q == EMIT_RD) begin
            word_nxt = make_cmd(CMD_READ, 32'h0);
          end
        end
      end

      EMIT_RD: begin
        if (rx_ok) begin
          err_nxt[1] = 1'b1;
        end
        if (!i_cmd_busy) begin
          state_nxt = IDLE;
          ret_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign o_cmd_stb  = (state_q == EMIT) || (state_q == EMIT_RD);
  assign o_cmd_word = word_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        busy = 1'b0;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  logic [33:0] got_q[$];

  typedef struct {
    logic [95:0] str;
    int          nwords;
    logic [33:0] w[3];
    logic [1:0]  err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  uart_cmd_parser dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_rx_stb   (rx_stb),
    .i_rx_data  (rx_data),
    .o_cmd_stb  (cmd_stb),
    .o_cmd_word (cmd_word),
    .i_cmd_busy (busy),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && cmd_stb === 1'b1) begin
      stb_cnt++;
      if (!busy) got_q.push_back(cmd_word);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rx_stb = 1'b0;
    busy   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    stb_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_stb = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_stb = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{96'("A1W1\r"),        2, '{34'h2_0000_0001, 34'h1_0000_0001, 34'h0}, 2'b00};
    vecs[1] = '{96'("A123456789\n"),  1, '{34'h2_2345_6789, 34'h0, 34'h0}, 2'b00};
    vecs[2] = '{96'("A1x\n"),         0, '{34'h0, 34'h0, 34'h0}, 2'b01};
    vecs[3] = '{96'("R"),             1, '{34'h0_0000_0000, 34'h0, 34'h0}, 2'b00};
    vecs[4] = '{96'("WBEEF "),        1, '{34'h1_0000_BEEF, 34'h0, 34'h0}, 2'b00};
    vecs[5] = '{96'("A\r"),           1, '{34'h2_0000_0000, 34'h0, 34'h0}, 2'b00};
    vecs[6] = '{96'("AW5R"),          3, '{34'h2_0000_0000, 34'h1_0000_0005, 34'h0_0000_0000}, 2'b00};
    vecs[7] = '{96'("5\n"),           0, '{34'h0, 34'h0, 34'h0}, 2'b01};
    vecs[8] = '{96'("A00000000FF\n"), 1, '{34'h2_0000_00FF, 34'h0, 34'h0}, 2'b00};
`ifdef UART_CMD_LOWERCASE_EN
    vecs[9] = '{96'("a1\n"),          1, '{34'h2_0000_0001, 34'h0, 34'h0}, 2'b00};
`else
    vecs[9] = '{96'("a1\n"),          0, '{34'h0, 34'h0, 34'h0}, 2'b01};
`endif

    rst_n = 1'b0;
    #3;
    check("reset stb", {33'h0, cmd_stb}, 34'h0);
    check("reset word", cmd_word, 34'h0);
    check("reset err", {32'h0, err}, 34'h0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int i = 11; i >= 0; i--) begin
        if (vecs[v].str[8*i +: 8] != 8'h00) send_gap(vecs[v].str[8*i +: 8]);
      end
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("v%0d word count", v), 34'(got_q.size()), 34'(vecs[v].nwords));
      check($sformatf("v%0d stb cycles", v), 34'(stb_cnt), 34'(vecs[v].nwords));
      for (int i = 0; i < vecs[v].nwords; i++) begin
        check($sformatf("v%0d word%0d", v, i),
              (i < got_q.size()) ? got_q[i] : 34'h3_FFFF_FFFF, vecs[v].w[i]);
      end
      check($sformatf("v%0d err", v), {32'h0, err}, {32'h0, vecs[v].err});
    end

    // write then read while the master stays busy for 20 cycles
    do_reset();
    busy = 1'b1;
    send_gap("W");
    send_gap("5");
    send_byte("R");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("busy hold stb %0d", i), {33'h0, cmd_stb}, 34'h1);
      check($sformatf("busy hold word %0d", i), cmd_word, 34'h1_0000_0005);
    end
    @(posedge clk);
    #1 busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("read follow stb", {33'h0, cmd_stb}, 34'h1);
    check("read follow word", cmd_word, 34'h0_0000_0000);
    @(negedge clk);
    check("after read stb", {33'h0, cmd_stb}, 34'h0);
    check("busy seq count", 34'(got_q.size()), 34'd2);
    check("busy seq w0", (got_q.size() > 0) ? got_q[0] : 34'h3_FFFF_FFFF, 34'h1_0000_0005);
    check("busy seq w1", (got_q.size() > 1) ? got_q[1] : 34'h3_FFFF_FFFF, 34'h0_0000_0000);

    // byte arriving while a command waits is dropped
    do_reset();
    busy = 1'b1;
    send_gap("W");
    send_gap("5");
    send_byte(8'h0D);
    send_byte("A");
    @(posedge clk);
    #1 busy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("drop count", 34'(got_q.size()), 34'd1);
    check("drop word", (got_q.size() > 0) ? got_q[0] : 34'h3_FFFF_FFFF, 34'h1_0000_0005);
    check("drop err", {32'h0, err}, 34'h2);

    // reset in the middle of "A12" leaves nothing pending
    do_reset();
    send_gap("A");
    send_gap("1");
    send_gap("2");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-cmd reset stb", {33'h0, cmd_stb}, 34'h0);
    check("mid-cmd reset word", cmd_word, 34'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_gap(8'h0D);
    repeat (3) @(posedge clk);
    #1;
    check("mid-cmd reset no cmd", 34'(got_q.size()), 34'd0);

    // reset while a command is being offered
    busy = 1'b1;
    send_gap("W");
    send_gap("5");
    send_byte(8'h0D);
    @(negedge clk);
    check("emit before reset stb", {33'h0, cmd_stb}, 34'h1);
    #2 rst_n = 1'b0;
    #1;
    check("emit reset stb", {33'h0, cmd_stb}, 34'h0);
    check("emit reset word", cmd_word, 34'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    busy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("emit reset no cmd", 34'(got_q.size()), 34'd0);
    send_gap("R");
    send_gap(8'h0A);
    repeat (3) @(posedge clk);
    #1;
    check("post reset read count", 34'(got_q.size()), 34'd1);
    check("post reset read word", (got_q.size() > 0) ? got_q[0] : 34'h3_FFFF_FFFF, 34'h0_0000_0000);
    check("post reset err", {32'h0, err}, 34'h0);

    // a strobe in the first cycle after release is ignored
    rst_n   = 1'b0;
    busy    = 1'b0;
    rx_stb  = 1'b1;
    rx_data = "R";
    @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
    stb_cnt = 0;
    @(posedge clk);
    #1 rx_stb = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("first cycle ignored count", 34'(got_q.size()), 34'd0);
    check("first cycle ignored stb", 34'(stb_cnt), 34'd0);
    check("first cycle ignored err", {32'h0, err}, 34'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
